// File: rtl/layer_sched_if.sv
// Handshake and datapath-control bundle between the layer sequencer and the MLP datapath.
// master = sequencer side (drives addresses/strobes), slave = top/datapath side (drives start/hold).
interface layer_sched_if #(
  parameter int NO_HL  = 2,
  parameter int NO_NIL = 784,
  parameter int NO_NHL = 28,
  parameter int NO_NOL = 10
);
  localparam int WW = $clog2(NO_NIL + NO_HL * NO_NHL);
  localparam int XW = $clog2(NO_NIL);
  localparam int AW = $clog2(NO_NHL);
  localparam int LW = $clog2(NO_HL + 1);

  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic [WW-1:0] w_addr;
  logic [XW-1:0] x_addr;
  logic [1:0]    x_src;
  logic          mac_clr;
  logic          mac_en;
  logic          act_en;
  logic          last_layer;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_dst;
  logic [LW-1:0] layer;

  modport master (
    input  start, hold,
    output busy, done, w_addr, x_addr, x_src, mac_clr, mac_en, act_en,
           last_layer, wr_en, wr_addr, wr_dst, layer
  );

  modport slave (
    output start, hold,
    input  busy, done, w_addr, x_addr, x_src, mac_clr, mac_en, act_en,
           last_layer, wr_en, wr_addr, wr_dst, layer
  );
endinterface

// File: rtl/layer_sched.sv
// Per-inference layer walker: CLR, MAC (N_in issues), DRAIN, ACT, WB (N_out writes), NEXT; done pulse at end.
// Latency 1+N_in+(1+MAC_LAT)+1+N_out+1 cycles per layer; hold stalls only the MAC address advance.
module layer_sched #(
  parameter int NO_HL   = 2,
  parameter int NO_NIL  = 784,
  parameter int NO_NHL  = 28,
  parameter int NO_NOL  = 10,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  layer_sched_if.master   bus
);
  localparam int WW   = $clog2(NO_NIL + NO_HL * NO_NHL);
  localparam int XW   = $clog2(NO_NIL);
  localparam int AW   = $clog2(NO_NHL);
  localparam int LW   = $clog2(NO_HL + 1);
  localparam int CM0  = (NO_NHL > NO_NOL) ? NO_NHL : NO_NOL;
  localparam int CMAX = (CM0 > MAC_LAT + 1) ? CM0 : MAC_LAT + 1;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_MAC, S_DRAIN, S_ACT, S_WB, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] i_q, i_d;
  logic [WW-1:0] w_addr_q, w_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          mac_en_q, mac_en_d;

  logic          is_last;
  logic [XW-1:0] n_in_m1;
  logic [CW-1:0] n_out_m1;
  logic [WW-1:0] base;

  always_comb begin
    is_last  = (layer_q == LW'(NO_HL));
    n_in_m1  = (layer_q == '0) ? XW'(NO_NIL - 1) : XW'(NO_NHL - 1);
    n_out_m1 = is_last ? CW'(NO_NOL - 1) : CW'(NO_NHL - 1);
    base     = '0;
    if (layer_q != '0) begin
      base = WW'(NO_NIL + (int'(layer_q) - 1) * NO_NHL);
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    w_addr_d = w_addr_q;
    cnt_d    = cnt_q;
    layer_d  = layer_q;
    mac_en_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLR;
          layer_d = '0;
        end
      end
      S_CLR: begin
        i_d      = '0;
        w_addr_d = base;
        cnt_d    = '0;
        state_d  = S_MAC;
      end
      S_MAC: begin
        // a held cycle issues nothing, so mac_en stays low one cycle later
        if (!bus.hold) begin
          mac_en_d = 1'b1;
          if (i_q == n_in_m1) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            i_d      = i_q + XW'(1);
            w_addr_d = w_addr_q + WW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(MAC_LAT)) begin
          state_d = S_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACT: begin
        state_d = S_WB;
        cnt_d   = '0;
      end
      S_WB: begin
        if (cnt_q == n_out_m1) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (is_last) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + LW'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        layer_d  = '0;
        i_d      = '0;
        w_addr_d = '0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      w_addr_q <= '0;
      cnt_q    <= '0;
      layer_q  <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      w_addr_q <= w_addr_d;
      cnt_q    <= cnt_d;
      layer_q  <= layer_d;
      mac_en_q <= mac_en_d;
    end
  end

  logic active;
  assign active = (state_q != S_IDLE);

  assign bus.busy       = active;
  assign bus.done       = (state_q == S_DONE);
  assign bus.mac_clr    = (state_q == S_CLR);
  assign bus.mac_en     = mac_en_q;
  assign bus.act_en     = (state_q == S_ACT);
  assign bus.wr_en      = (state_q == S_WB);
  assign bus.wr_addr    = (state_q == S_WB) ? AW'(cnt_q) : '0;
  assign bus.w_addr     = w_addr_q;
  assign bus.x_addr     = i_q;
  assign bus.layer      = layer_q;
  assign bus.last_layer = active && is_last;
  assign bus.wr_dst     = active && layer_q[0];

  // layer k>0 reads what layer k-1 wrote: odd k -> buffer A, even k -> buffer B
  always_comb begin
    bus.x_src = 2'd0;
    if (active && (layer_q != '0)) begin
      bus.x_src = layer_q[0] ? 2'd1 : 2'd2;
    end
  end
endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: default run, address map, hold stress, start misuse, mid-run reset, parameter sweep.
module tb_layer_sched;
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer_sched_if #(.NO_HL(2), .NO_NIL(784), .NO_NHL(28), .NO_NOL(10)) ifc ();
  layer_sched_if #(.NO_HL(1), .NO_NIL(784), .NO_NHL(28), .NO_NOL(10)) ifc2 ();

  layer_sched #(.NO_HL(2), .NO_NIL(784), .NO_NHL(28), .NO_NOL(10), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  layer_sched #(.NO_HL(1), .NO_NIL(784), .NO_NHL(28), .NO_NOL(10), .MAC_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2)
  );

  int checks = 0;
  int errors = 0;

  int done_cyc, last_done, done_cnt, mac_cnt, act_cnt, held, addr_err, ll_err, layer_c1;
  int done_list[2];
  int wr_cnt[3], iss_cnt[3], w_first[3], w_last[3], src_s[3], dst_s[3];

  // Starts one inference on dut and gathers observations cycle by cycle (cycle 1 = first cycle after start is sampled).
  task automatic run(input bit rnd_hold, input int sp1, input int sp2, input bit hold_start,
                     input int max_cyc, input int tail);
    logic [9:0] pw, px;
    logic [1:0] pl, psrc;
    bit in_mac, prev_clr, hv;
    int n_iss, nin, k, need;
    done_cyc = -1; last_done = -1; done_cnt = 0; mac_cnt = 0; act_cnt = 0;
    held = 0; addr_err = 0; ll_err = 0; layer_c1 = -1;
    done_list[0] = -1; done_list[1] = -1;
    for (int j = 0; j < 3; j++) begin
      wr_cnt[j] = 0; iss_cnt[j] = 0; w_first[j] = -1; w_last[j] = -1; src_s[j] = -1; dst_s[j] = -1;
    end
    pw = '0; px = '0; pl = '0; psrc = '0;
    in_mac = 0; prev_clr = 0; n_iss = 0; nin = 0;
    need = hold_start ? 2 : 1;
    ifc.start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (cyc == 1) layer_c1 = int'(ifc.layer);
      if (ifc.mac_en) begin
        mac_cnt++;
        k = int'(pl);
        if (k < 3) begin
          if (iss_cnt[k] == 0) begin
            w_first[k] = int'(pw);
            src_s[k]   = int'(psrc);
          end else if (int'(pw) != w_last[k] + 1) begin
            addr_err++;
          end
          if (int'(px) != iss_cnt[k]) addr_err++;
          w_last[k] = int'(pw);
          iss_cnt[k]++;
        end
      end
      if (ifc.act_en) act_cnt++;
      if (ifc.wr_en) begin
        k = int'(ifc.layer);
        if (k < 3) begin
          if (int'(ifc.wr_addr) != wr_cnt[k]) addr_err++;
          wr_cnt[k]++;
          dst_s[k] = int'(ifc.wr_dst);
        end
      end
      if (ifc.busy && (ifc.last_layer !== (ifc.layer == 2'd2))) ll_err++;
      if (!ifc.busy && ifc.last_layer) ll_err++;
      if (ifc.done) begin
        if (done_cnt < 2) done_list[done_cnt] = cyc;
        done_cnt++;
        last_done = cyc;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (prev_clr) begin
        in_mac = 1; n_iss = 0;
        nin = (ifc.layer == 2'd0) ? 784 : 28;
      end
      hv = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
      ifc.hold = hv;
      if (in_mac) begin
        if (hv) held++;
        else begin
          n_iss++;
          if (n_iss == nin) in_mac = 0;
        end
      end
      prev_clr = ifc.mac_clr;
      ifc.start = (cyc == sp1) || (cyc == sp2) || (hold_start && done_cnt < 2);
      pw = ifc.w_addr; px = ifc.x_addr; pl = ifc.layer; psrc = ifc.x_src;
      if (done_cnt >= need && cyc >= last_done + tail) break;
      @(negedge clk);
    end
    ifc.start = 1'b0;
    ifc.hold  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [36:0] v;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    v = {ifc.busy, ifc.done, ifc.mac_clr, ifc.mac_en, ifc.act_en, ifc.wr_en, ifc.last_layer,
         ifc.wr_dst, ifc.w_addr, ifc.x_addr, ifc.x_src, ifc.wr_addr, ifc.layer};
    checks++;
    if (v !== 37'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", v); end
    checks++;
    if (ifc2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b want 0", ifc2.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_run();
    int exp_wr[3] = '{28, 28, 10};
    run(1'b0, 0, 0, 1'b0, 1000, 5);
    checks++;
    if (done_cyc !== 925) begin errors++; $display("FAIL default_done_cycle got %0d want 925", done_cyc); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL default_done_count got %0d want 1", done_cnt); end
    checks++;
    if (mac_cnt !== 840) begin errors++; $display("FAIL default_mac_en got %0d want 840", mac_cnt); end
    checks++;
    if (act_cnt !== 3) begin errors++; $display("FAIL default_act_en got %0d want 3", act_cnt); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (wr_cnt[j] !== exp_wr[j]) begin
        errors++; $display("FAIL default_wr_count layer %0d got %0d want %0d", j, wr_cnt[j], exp_wr[j]);
      end
    end
    checks++;
    if (addr_err !== 0) begin errors++; $display("FAIL default_addr_seq got %0d errors want 0", addr_err); end
    checks++;
    if (layer_c1 !== 0) begin errors++; $display("FAIL default_first_layer got %0d want 0", layer_c1); end
  endtask

  task automatic test_addr_map();
    int ef[3] = '{0, 784, 812};
    int el[3] = '{783, 811, 839};
    int es[3] = '{0, 1, 2};
    int ed[3] = '{0, 1, 0};
    run(1'b0, 0, 0, 1'b0, 1000, 5);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (w_first[j] !== ef[j]) begin errors++; $display("FAIL w_addr_first L%0d got %0d want %0d", j, w_first[j], ef[j]); end
      checks++;
      if (w_last[j] !== el[j]) begin errors++; $display("FAIL w_addr_last L%0d got %0d want %0d", j, w_last[j], el[j]); end
      checks++;
      if (src_s[j] !== es[j]) begin errors++; $display("FAIL x_src L%0d got %0d want %0d", j, src_s[j], es[j]); end
      checks++;
      if (dst_s[j] !== ed[j]) begin errors++; $display("FAIL wr_dst L%0d got %0d want %0d", j, dst_s[j], ed[j]); end
    end
    checks++;
    if (ll_err !== 0) begin errors++; $display("FAIL last_layer got %0d bad cycles want 0", ll_err); end
  endtask

  task automatic test_hold_stress();
    run(1'b1, 0, 0, 1'b0, 3000, 5);
    checks++;
    if (mac_cnt !== 840) begin errors++; $display("FAIL hold_mac_en got %0d want 840", mac_cnt); end
    checks++;
    if (addr_err !== 0) begin errors++; $display("FAIL hold_addr_seq got %0d errors want 0", addr_err); end
    checks++;
    if (done_cyc !== 925 + held) begin errors++; $display("FAIL hold_done_cycle got %0d want %0d", done_cyc, 925 + held); end
    checks++;
    if (held < 100) begin errors++; $display("FAIL hold_stream_density got %0d held cycles want >=100", held); end
  endtask

  task automatic test_start_misuse();
    run(1'b0, 10, 500, 1'b0, 1300, 200);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL misuse_done_count got %0d want 1", done_cnt); end
    checks++;
    if (done_cyc !== 925) begin errors++; $display("FAIL misuse_done_cycle got %0d want 925", done_cyc); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL misuse_idle_after got %b want 0", ifc.busy); end
  endtask

  task automatic test_back_to_back();
    run(1'b0, 0, 0, 1'b1, 2000, 3);
    checks++;
    if (done_list[0] !== 925) begin errors++; $display("FAIL b2b_done1 got %0d want 925", done_list[0]); end
    // second run's start is sampled in the IDLE cycle 926, so its done lands 925 cycles later
    checks++;
    if (done_list[1] !== 1851) begin errors++; $display("FAIL b2b_done2 got %0d want 1851", done_list[1]); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %b want 0", ifc.busy); end
  endtask

  task automatic test_reset_mid();
    logic [36:0] v;
    int seen = 0;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int c = 1; c < 830; c++) begin
      if (ifc.done) seen++;
      @(negedge clk);
    end
    checks++;
    if (ifc.layer !== 2'd1) begin errors++; $display("FAIL midrst_layer_before got %0d want 1", ifc.layer); end
    rst_n = 1'b0;
    #1;
    v = {ifc.busy, ifc.done, ifc.mac_clr, ifc.mac_en, ifc.act_en, ifc.wr_en, ifc.last_layer,
         ifc.wr_dst, ifc.w_addr, ifc.x_addr, ifc.x_src, ifc.wr_addr, ifc.layer};
    checks++;
    if (v !== 37'd0) begin errors++; $display("FAIL midrst_async_outputs got %h want 0", v); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ifc.done) seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d events want 0", seen); end
    run(1'b0, 0, 0, 1'b0, 1000, 5);
    checks++;
    if (layer_c1 !== 0) begin errors++; $display("FAIL midrst_restart_layer got %0d want 0", layer_c1); end
    checks++;
    if (done_cyc !== 925) begin errors++; $display("FAIL midrst_done_cycle got %0d want 925", done_cyc); end
  endtask

  task automatic test_param_sweep();
    int d = -1, macs = 0, acts = 0, w0 = 0, w1 = 0, lastmac = 0, gap_err = 0, ll2 = 0;
    ifc2.hold  = 1'b0;
    ifc2.start = 1'b1;
    @(negedge clk);
    ifc2.start = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (ifc2.mac_en) begin macs++; lastmac = c; end
      if (ifc2.act_en) begin
        acts++;
        if (c - lastmac != 4) gap_err++;
      end
      if (ifc2.wr_en) begin
        if (ifc2.layer == 1'b0) w0++; else w1++;
      end
      if (ifc2.busy && (ifc2.last_layer !== (ifc2.layer == 1'b1))) ll2++;
      if (ifc2.done && d < 0) d = c;
      if (d > 0 && c > d + 3) break;
      @(negedge clk);
    end
    checks++;
    if (d !== 865) begin errors++; $display("FAIL sweep_done_cycle got %0d want 865", d); end
    checks++;
    if (macs !== 812) begin errors++; $display("FAIL sweep_mac_en got %0d want 812", macs); end
    checks++;
    if (acts !== 2) begin errors++; $display("FAIL sweep_act_en got %0d want 2", acts); end
    checks++;
    if (w0 !== 28 || w1 !== 10) begin errors++; $display("FAIL sweep_wr_count got %0d/%0d want 28/10", w0, w1); end
    checks++;
    if (gap_err !== 0) begin errors++; $display("FAIL sweep_drain_len got %0d bad gaps want 0", gap_err); end
    checks++;
    if (ll2 !== 0) begin errors++; $display("FAIL sweep_last_layer got %0d bad cycles want 0", ll2); end
  endtask

  initial begin
    ifc.start  = 1'b0;
    ifc.hold   = 1'b0;
    ifc2.start = 1'b0;
    ifc2.hold  = 1'b0;
    test_reset();
    test_default_run();
    test_addr_map();
    test_hold_stress();
    test_start_misuse();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
